// File: rtl/music_sequencer.sv
// music_sequencer: plays one of four hard-coded melodies as a square wave.
// The one-hot `music` select picks the song; any change of the select restarts
// playback from note 0 (or parks the block in IDLE if the select is not one-hot).
// INIT and PLAY loop forever; WIN and LOSS play once and then hold in DONE.
module music_sequencer #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] music,
    output logic       audio_pwm,
    output logic       audio_sd,
    output logic [3:0] note_idx,
    output logic       playing,
    output logic       song_done
);

    // Tone half-periods in clock cycles, fixed at elaboration.
    localparam int unsigned HALF_C4 = CLK_HZ / (2 * 262);
    localparam int unsigned HALF_D4 = CLK_HZ / (2 * 294);
    localparam int unsigned HALF_E4 = CLK_HZ / (2 * 330);
    localparam int unsigned HALF_F4 = CLK_HZ / (2 * 349);
    localparam int unsigned HALF_G4 = CLK_HZ / (2 * 392);
    localparam int unsigned HALF_A4 = CLK_HZ / (2 * 440);
    localparam int unsigned HALF_B4 = CLK_HZ / (2 * 494);
    localparam int unsigned HALF_C5 = CLK_HZ / (2 * 523);

    // C4 is the lowest note, so it sets the tone counter width.
    localparam int unsigned BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned TONE_W = (HALF_C4 > 1) ? $clog2(HALF_C4) : 1;

    // Last beat count of a note, and the last count before the silent gap.
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [BEAT_W-1:0] GAP_LAST  = BEAT_W'(BEAT_CYCLES - GAP_CYCLES - 1);

    // Melody tables; note codes 1..8 are C4..C5, 0 is a rest.
    localparam logic [3:0] INIT_ROM [8]  = '{4'd1, 4'd3, 4'd5, 4'd8, 4'd5, 4'd3, 4'd1, 4'd0};
    localparam logic [3:0] PLAY_ROM [16] = '{4'd1, 4'd1, 4'd5, 4'd5, 4'd6, 4'd6, 4'd5, 4'd0,
                                             4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0};
    localparam logic [3:0] WIN_ROM [8]   = '{4'd1, 4'd3, 4'd5, 4'd8, 4'd5, 4'd8, 4'd8, 4'd8};
    localparam logic [3:0] LOSS_ROM [4]  = '{4'd5, 4'd4, 4'd3, 4'd1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY_NOTE,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SONG_INIT,
        SONG_PLAY,
        SONG_WIN,
        SONG_LOSS
    } song_e;

    // Registered state
    state_e              state_q, state_d;
    song_e               song_q, song_d;
    logic [3:0]          music_q;
    logic [3:0]          note_q, note_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic                pwm_q, pwm_d;
    logic                done_q, done_d;

    // Decoded helpers
    logic                restart;
    logic                sel_valid;
    song_e               sel_song;
    logic [3:0]          cur_note;
    logic [3:0]          last_idx;
    logic                one_shot;
    logic                tone_note;
    logic [TONE_W-1:0]   half_m1;

    assign restart = (music != music_q);

    // Decode the raw select into a song; anything but exactly one-hot is invalid.
    always_comb begin
        sel_valid = 1'b1;
        sel_song  = SONG_INIT;
        case (music)
            4'b0001: sel_song  = SONG_INIT;
            4'b0010: sel_song  = SONG_PLAY;
            4'b0100: sel_song  = SONG_WIN;
            4'b1000: sel_song  = SONG_LOSS;
            default: sel_valid = 1'b0;
        endcase
    end

    // Look up the current note code, the song's last index and its looping mode.
    always_comb begin
        cur_note = 4'd0;
        last_idx = 4'd0;
        one_shot = 1'b0;
        case (song_q)
            SONG_INIT: begin
                cur_note = INIT_ROM[note_q[2:0]];
                last_idx = 4'd7;
            end
            SONG_PLAY: begin
                cur_note = PLAY_ROM[note_q];
                last_idx = 4'd15;
            end
            SONG_WIN: begin
                cur_note = WIN_ROM[note_q[2:0]];
                last_idx = 4'd7;
                one_shot = 1'b1;
            end
            SONG_LOSS: begin
                cur_note = LOSS_ROM[note_q[1:0]];
                last_idx = 4'd3;
                one_shot = 1'b1;
            end
            default: ;
        endcase
    end

    // Map the note code to its half-period minus one; codes outside 1..8 rest.
    always_comb begin
        tone_note = 1'b1;
        half_m1   = '0;
        case (cur_note)
            4'd1:    half_m1 = TONE_W'(HALF_C4 - 1);
            4'd2:    half_m1 = TONE_W'(HALF_D4 - 1);
            4'd3:    half_m1 = TONE_W'(HALF_E4 - 1);
            4'd4:    half_m1 = TONE_W'(HALF_F4 - 1);
            4'd5:    half_m1 = TONE_W'(HALF_G4 - 1);
            4'd6:    half_m1 = TONE_W'(HALF_A4 - 1);
            4'd7:    half_m1 = TONE_W'(HALF_B4 - 1);
            4'd8:    half_m1 = TONE_W'(HALF_C5 - 1);
            default: tone_note = 1'b0;
        endcase
    end

    // Next-state and datapath logic; a restart overrides beat and DONE events.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        song_d  = song_q;
        note_d  = note_q;
        beat_d  = beat_q;
        tone_d  = tone_q;
        pwm_d   = pwm_q;
        done_d  = 1'b0;

        if (restart) begin
            note_d = 4'd0;
            beat_d = '0;
            tone_d = '0;
            pwm_d  = 1'b0;
            if (sel_valid) begin
                state_d = ST_PLAY_NOTE;
                song_d  = sel_song;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_PLAY_NOTE: begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
                        tone_d = '0;
                        pwm_d  = 1'b0;
                        if (note_q != last_idx) begin
                            note_d = note_q + 4'd1;
                        end else if (one_shot) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            note_d = 4'd0;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        // Look one count ahead so the pin is already low on the
                        // first gap cycle rather than one cycle late.
                        if (!tone_note || (beat_q >= GAP_LAST)) begin
                            tone_d = '0;
                            pwm_d  = 1'b0;
                        end else if (tone_q == half_m1) begin
                            tone_d = '0;
                            pwm_d  = ~pwm_q;
                        end else begin
                            tone_d = tone_q + TONE_W'(1);
                        end
                    end
                end
                default: begin
                    // IDLE and DONE: silent, counters parked, note index held.
                    beat_d = '0;
                    tone_d = '0;
                    pwm_d  = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous reset; the select is sampled every cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from the
        // values of the previous cycle, independent of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            song_q  <= SONG_INIT;
            music_q <= 4'b0000;
            note_q  <= 4'd0;
            beat_q  <= '0;
            tone_q  <= '0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            music_q <= music;
            note_q  <= note_d;
            beat_q  <= beat_d;
            tone_q  <= tone_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
        end
    end

    assign audio_pwm = pwm_q;
    assign playing   = (state_q == ST_PLAY_NOTE);
    assign audio_sd  = playing;
    assign note_idx  = note_q;
    assign song_done = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Testbench for music_sequencer: table-driven vectors for reset, INIT and LOSS,
// followed by hand-written sequences for illegal selects, the rest note, a
// mid-song switch and a reset in the middle of the WIN song.
module tb_music_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] music;
    logic       audio_pwm;
    logic       audio_sd;
    logic [3:0] note_idx;
    logic       playing;
    logic       song_done;

    int checks = 0;
    int errors = 0;

    music_sequencer #(
        .CLK_HZ     (100_000),
        .BEAT_CYCLES(2000),
        .GAP_CYCLES (200)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .music    (music),
        .audio_pwm(audio_pwm),
        .audio_sd (audio_sd),
        .note_idx (note_idx),
        .playing  (playing),
        .song_done(song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] music;
        int         cycles;
        logic       pwm;
        logic       sd;
        logic [3:0] idx;
        logic       play;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    // Output bundle in the order {pwm, sd, idx[3:0], playing, done}.
    function automatic logic [7:0] outs();
        return {audio_pwm, audio_sd, note_idx, playing, song_done};
    endfunction

    function automatic logic [7:0] pack(input logic pwm, input logic sd, input logic [3:0] idx,
                                        input logic play, input logic done);
        return {pwm, sd, idx, play, done};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b ({pwm,sd,idx,playing,done})", name, act, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] m, input int n, input logic pwm,
                       input logic sd, input logic [3:0] idx, input logic play, input logic done);
        vec_t v;
        v.rst = r; v.music = m; v.cycles = n;
        v.pwm = pwm; v.sd = sd; v.idx = idx; v.play = play; v.done = done;
        vecs.push_back(v);
    endtask

    initial begin
        int bad;
        rst   = 1'b1;
        music = 4'b0001;

        // Offsets s below count edges after the restart edge (s=0: playing=1).
        //      rst   music    n      pwm   sd    idx    play  done
        add(1'b1, 4'b0001,     3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0); // in reset: all 0
        add(1'b0, 4'b0001,     1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // INIT s=0
        add(1'b0, 4'b0001,   189, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // s=189 C4 still low
        add(1'b0, 4'b0001,     1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0); // s=190 first rise
        add(1'b0, 4'b0001,   189, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0); // s=379 still high
        add(1'b0, 4'b0001,     1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // s=380 fall, period 380
        add(1'b0, 4'b0001,  1419, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0); // s=1799 last tone cycle
        add(1'b0, 4'b0001,     1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // s=1800 gap begins
        add(1'b0, 4'b0001,   199, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // s=1999 gap end
        add(1'b0, 4'b0001,     1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0); // s=2000 next note
        add(1'b0, 4'b0001,   150, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0); // s=2150 E4 still low
        add(1'b0, 4'b0001,     1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0); // s=2151 E4 rise
        add(1'b0, 4'b0001, 13848, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0); // s=15999 last note (rest)
        add(1'b0, 4'b0001,     1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // s=16000 wrap to 0
        add(1'b0, 4'b1000,     1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // LOSS s=0
        add(1'b0, 4'b1000,   126, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // s=126 G4 low
        add(1'b0, 4'b1000,     1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0); // s=127 G4 rise
        add(1'b0, 4'b1000,  2015, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0); // s=2142 F4 low
        add(1'b0, 4'b1000,     1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0); // s=2143 F4 rise
        add(1'b0, 4'b1000,  2008, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0); // s=4151 E4 rise
        add(1'b0, 4'b1000,  2039, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0); // s=6190 C4 rise
        add(1'b0, 4'b1000,  1809, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0); // s=7999 last cycle
        add(1'b0, 4'b1000,     1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1); // s=8000 DONE + pulse
        add(1'b0, 4'b1000,     1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0); // s=8001 pulse gone
        add(1'b0, 4'b1000,  4000, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0); // stays in DONE

        foreach (vecs[i]) begin
            rst   = vecs[i].rst;
            music = vecs[i].music;
            tick(vecs[i].cycles);
            check($sformatf("vec%0d", i), outs(),
                  pack(vecs[i].pwm, vecs[i].sd, vecs[i].idx, vecs[i].play, vecs[i].done));
        end

        // Illegal selects park the block in IDLE with every output low.
        music = 4'b0011; tick(1);
        check("illegal_multi_hot", outs(), pack(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        music = 4'b0000; tick(1);
        check("illegal_zero", outs(), pack(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        tick(50);
        check("idle_hold", outs(), pack(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));

        // Back to PLAY: restarts from note 0.
        music = 4'b0010; tick(1);
        check("play_restart", outs(), pack(1'b0, 1'b1, 4'd0, 1'b1, 1'b0));
        tick(13999);
        check("play_before_rest", {4'd0, note_idx}, 8'd6);

        // Note 7 of PLAY is a rest: pin low for the whole beat, amplifier on.
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            tick(1);
            if (audio_pwm !== 1'b0 || audio_sd !== 1'b1 || note_idx !== 4'd7) bad++;
        end
        check("rest_note_bad_cycles", 8'(bad), 8'd0);
        tick(1);
        check("play_after_rest", outs(), pack(1'b0, 1'b1, 4'd8, 1'b1, 1'b0));

        // Mid-song switch from PLAY to WIN.
        music = 4'b0000; tick(1);
        music = 4'b0010; tick(1);
        tick(5000);
        check("play_s5000", outs(), pack(1'b1, 1'b1, 4'd2, 1'b1, 1'b0));
        music = 4'b0100; tick(1);
        check("win_switch", outs(), pack(1'b0, 1'b1, 4'd0, 1'b1, 1'b0));
        tick(189);
        check("win_s189", outs(), pack(1'b0, 1'b1, 4'd0, 1'b1, 1'b0));
        tick(1);
        check("win_s190", outs(), pack(1'b1, 1'b1, 4'd0, 1'b1, 1'b0));
        tick(1810);
        check("win_s2000", outs(), pack(1'b0, 1'b1, 4'd1, 1'b1, 1'b0));
        tick(6500);
        check("win_s8500", outs(), pack(1'b1, 1'b1, 4'd4, 1'b1, 1'b0));

        // Reset during WIN note 4, select held: restart right after release.
        rst = 1'b1; tick(1);
        check("reset_mid_song", outs(), pack(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        rst = 1'b0; tick(1);
        check("win_after_reset", outs(), pack(1'b0, 1'b1, 4'd0, 1'b1, 1'b0));
        tick(15999);
        check("win_s15999", outs(), pack(1'b0, 1'b1, 4'd7, 1'b1, 1'b0));
        tick(1);
        check("win_done_pulse", outs(), pack(1'b0, 1'b0, 4'd7, 1'b0, 1'b1));
        tick(1);
        check("win_done_hold", outs(), pack(1'b0, 1'b0, 4'd7, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
